// File: rtl/tart_corr_pkg.sv
// tart_corr_pkg
// Shared definitions for the correlator scheduler and its readback engine:
// register-map geometry (NGRP groups of NREG registers, group index in
// adr[6:4], register index in adr[3:0]), the reader state encoding, and
// helpers that walk the sparse register map.
package tart_corr_pkg;

   localparam int NGRP = 8;
   localparam int NREG = 12;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_WAIT  = 2'd1,
      R_BURST = 2'd2,
      R_DONE  = 2'd3
   } rd_state_t;

   // Address of the last visibility register: final register of the final group.
   function automatic logic [6:0] final_adr(input int ngrp, input int nreg);
      return 7'((ngrp - 1) * 16 + (nreg - 1));
   endfunction

   // Next register address. Registers occupy only 0..nreg-1 of each 16-slot
   // group, so stepping past the last one jumps to slot 0 of the next group.
   function automatic logic [6:0] adr_next(input logic [6:0] adr, input int nreg);
      if (adr[3:0] == 4'(nreg - 1)) begin
         return adr + 7'(16 - nreg + 1);
      end
      return adr + 7'd1;
   endfunction

endpackage

// File: rtl/corr_readback.sv
// corr_readback
// Reader FSM for the retired correlator bank. A bank-switch pulse starts a
// settle delay, then a Wishbone burst over every visibility register. Each
// acknowledged word lands in a one-deep output register feeding a
// valid/ready stream; the bus is only strobed when that register can take
// the word, so backpressure stalls the burst without loss or duplication.
//
// Ports:
//   clk_i, rst                 clock, synchronous active-low reset
//   sw                         bank-switch pulse (starts a readback from idle)
//   cyc, stb, bst, adr         Wishbone master controls and register address
//   ack, dat                   Wishbone acknowledge and read data
//   vis_valid/ready/data/last  visibility stream out
//   busy                       reader not idle
module corr_readback
   import tart_corr_pkg::*;
#(
   parameter int GROUPS = NGRP,
   parameter int REGS   = NREG,
   parameter int SETTLE = 4
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        sw,
   output logic        cyc,
   output logic        stb,
   output logic        bst,
   output logic [6:0]  adr,
   input  logic        ack,
   input  logic [31:0] dat,
   output logic        vis_valid,
   input  logic        vis_ready,
   output logic [31:0] vis_data,
   output logic        vis_last,
   output logic        busy
);

   localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
   localparam logic [6:0]    LAST      = final_adr(GROUPS, REGS);

   rd_state_t     state,    state_n;
   logic [SW-1:0] settle_q, settle_n;
   logic [6:0]    adr_q,    adr_n;
   logic [31:0]   data_q,   data_n;
   logic          valid_q,  valid_n;
   logic          last_q,   last_n;

   always_ff @(posedge clk_i) begin
      if (!rst) begin
         state    <= R_IDLE;
         settle_q <= '0;
         adr_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state    <= state_n;
         settle_q <= settle_n;
         adr_q    <= adr_n;
         data_q   <= data_n;
         valid_q  <= valid_n;
         last_q   <= last_n;
      end
   end

   always_comb begin
      state_n  = state;
      settle_n = settle_q;
      adr_n    = adr_q;
      data_n   = data_q;
      valid_n  = valid_q;
      last_n   = last_q;
      cyc      = 1'b0;
      stb      = 1'b0;
      bst      = 1'b0;

      unique case (state)
         R_IDLE: begin
            if (sw) begin
               adr_n = '0;
               if (SETTLE == 0) begin
                  state_n = R_BURST;
               end else begin
                  state_n  = R_WAIT;
                  settle_n = SETTLE_LD;
               end
            end
         end
         // Leaving on the count of 1 makes the first strobe land exactly
         // SETTLE+1 cycles after the switch pulse.
         R_WAIT: begin
            if (settle_q <= SW'(1)) begin
               settle_n = '0;
               state_n  = R_BURST;
            end else begin
               settle_n = settle_q - SW'(1);
            end
         end
         R_BURST: begin
            cyc = 1'b1;
            stb = !valid_q || vis_ready;
            bst = (adr_q != LAST);
            if (stb && ack) begin
               if (adr_q == LAST) begin
                  adr_n   = '0;
                  state_n = R_DONE;
               end else begin
                  adr_n = adr_next(adr_q, REGS);
               end
            end
         end
         R_DONE: begin
            if (valid_q && vis_ready) begin
               state_n = R_IDLE;
            end
         end
         default: state_n = R_IDLE;
      endcase

      // stb is only raised when the register is empty or draining, so a
      // capture may overwrite a word that the consumer takes this cycle.
      if (stb && ack) begin
         data_n  = dat;
         valid_n = 1'b1;
         last_n  = (adr_q == LAST);
      end else if (valid_q && vis_ready) begin
         valid_n = 1'b0;
         last_n  = 1'b0;
      end
   end

   assign adr       = adr_q;
   assign vis_valid = valid_q;
   assign vis_data  = data_q;
   assign vis_last  = last_q;
   assign busy      = (state != R_IDLE);

endmodule

// File: rtl/correlator_sched.sv
// correlator_sched
// Sequences a correlator_block: counts enabled antenna sample strobes,
// pulses the bank switch every COUNT samples (toggling the accumulating
// bank), and hands the retired bank to corr_readback for a Wishbone burst
// read streamed out on the vis_* interface. A switch that arrives while a
// readback is still running raises the sticky overrun flag and is not
// queued.
//
// Ports:
//   clk_i, rst                  clock, synchronous active-low reset
//   en_i, strobe_i, clr_i       acquisition enable, sample strobe, overrun clear
//   en_o, sw_o, bank_o          correlator enable, bank-switch pulse, active bank
//   cyc_o, stb_o, we_o, bst_o   Wishbone master controls (read only)
//   adr_o, ack_i, dat_i         Wishbone address, acknowledge, read data
//   vis_valid_o, vis_ready_i,
//   vis_data_o, vis_last_o      visibility stream
//   overrun_o, busy_o           sticky overrun, reader not idle
module correlator_sched #(
   parameter int COUNT  = 96,
   parameter int NGRP   = tart_corr_pkg::NGRP,
   parameter int NREG   = tart_corr_pkg::NREG,
   parameter int SETTLE = 4,
   parameter int DELAY  = 3
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        en_i,
   input  logic        strobe_i,
   input  logic        clr_i,
   output logic        en_o,
   output logic        sw_o,
   output logic        bank_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic        bst_o,
   output logic [6:0]  adr_o,
   input  logic        ack_i,
   input  logic [31:0] dat_i,
   output logic        vis_valid_o,
   input  logic        vis_ready_i,
   output logic [31:0] vis_data_o,
   output logic        vis_last_o,
   output logic        overrun_o,
   output logic        busy_o
);

   localparam int            CW       = $clog2(COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

   // DELAY only shapes assignment timing in behavioural models; this
   // implementation is purely cycle-based.
   localparam int unused_delay = DELAY;

   logic [CW-1:0] scnt;

   // Sample counter and bank switch. With en_i low the count simply holds,
   // so a partially filled bank stays pending until acquisition resumes.
   // An overrun is judged against the reader state in the pulse cycle: the
   // reader only acts on sw_o while idle, so a busy reader drops it.
   always_ff @(posedge clk_i) begin
      if (!rst) begin
         scnt      <= '0;
         sw_o      <= 1'b0;
         bank_o    <= 1'b0;
         en_o      <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         en_o <= en_i;
         sw_o <= 1'b0;
         if (strobe_i && en_i) begin
            if (scnt == CNT_LAST) begin
               scnt   <= '0;
               sw_o   <= 1'b1;
               bank_o <= !bank_o;
            end else begin
               scnt <= scnt + CW'(1);
            end
         end
         if (sw_o && busy_o) begin
            overrun_o <= 1'b1;
         end else if (clr_i) begin
            overrun_o <= 1'b0;
         end
      end
   end

   assign we_o = 1'b0;

   corr_readback #(
      .GROUPS (NGRP),
      .REGS   (NREG),
      .SETTLE (SETTLE)
   ) u_readback (
      .clk_i     (clk_i),
      .rst       (rst),
      .sw        (sw_o),
      .cyc       (cyc_o),
      .stb       (stb_o),
      .bst       (bst_o),
      .adr       (adr_o),
      .ack       (ack_i),
      .dat       (dat_i),
      .vis_valid (vis_valid_o),
      .vis_ready (vis_ready_i),
      .vis_data  (vis_data_o),
      .vis_last  (vis_last_o),
      .busy      (busy_o)
   );

endmodule
